// File: rtl/eth_parser_pkg.sv
// Shared types and limits for the ethernet parser front-end blocks.
package eth_parser_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int ARB_MAX_PORTS = 16;
  localparam int ARB_CNT_W     = 32;

endpackage

// File: rtl/eth_tag_fifo.sv
// Source-port tag FIFO: one entry per granted frame, popped per parser metadata completion.
module eth_tag_fifo #(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             underflow_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             uf_q, uf_d;
  logic             do_push_s, do_pop_s;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty_o     = (wr_q == rd_q);
  assign full_o      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push_s   = push_i & ~full_o;
  assign do_pop_s    = pop_i & ~empty_o;
  assign dout_o      = mem_q[rd_q[AW-1:0]];
  assign underflow_o = uf_q;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    uf_d = uf_q | (pop_i & empty_o);
    if (do_push_s) begin
      wr_d = wr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_d = wr_q;
    end
    if (do_pop_s) begin
      rd_d = rd_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_d = rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= {(AW+1){1'b0}};
      rd_q <= {(AW+1){1'b0}};
      uf_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      uf_q <= uf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/eth_parser_port_arbiter.sv
// Frame-granular round-robin arbiter sharing one parser between NUM_PORTS AXI-Stream ports.
// Define ETH_ARB_STATS_EN to add per-port completed-frame counters on frame_count.
module eth_parser_port_arbiter
  import eth_parser_pkg::*;
#(
  parameter  int NUM_PORTS  = 4,
  parameter  int DATA_WIDTH = 64,
  parameter  int TAG_DEPTH  = 4,
  localparam int PORT_W     = $clog2(NUM_PORTS)
) (
`ifdef ETH_ARB_STATS_EN
  output logic [NUM_PORTS*ARB_CNT_W-1:0]  frame_count,
`endif
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [PORT_W-1:0]               grant_port,
  output logic                            busy,
  input  logic                            meta_done,
  output logic [PORT_W-1:0]               meta_port,
  output logic                            meta_port_valid,
  output logic                            tag_full,
  output logic                            tag_underflow
);

  arb_state_t        state_q, state_d;
  logic [PORT_W-1:0] grant_q, grant_d;
  logic [PORT_W-1:0] last_q, last_d;
  logic              tag_push_s, tag_empty_s, eop_s;

  // First valid port strictly after the last winner, wrapping modulo NUM_PORTS.
  function automatic logic [PORT_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] valid,
                                                input logic [PORT_W-1:0]    last);
    logic [PORT_W-1:0] pick;
    logic              found;
    int                idx;
    pick  = {PORT_W{1'b0}};
    found = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = (int'(last) + i) % NUM_PORTS;
      if (!found && valid[idx]) begin
        pick  = PORT_W'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  assign busy       = (state_q == ARB_BUSY);
  assign grant_port = grant_q;
  assign eop_s      = busy & m_axis_tvalid & m_axis_tready & m_axis_tlast;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    tag_push_s = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if ((|s_axis_tvalid) && !tag_full) begin
          grant_d    = rr_pick(s_axis_tvalid, last_q);
          tag_push_s = 1'b1;
          state_d    = ARB_BUSY;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        if (eop_s) begin
          last_d  = grant_q;
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_BUSY;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Zero-latency pass-through of the locked port; everything idles low otherwise.
  always_comb begin
    m_axis_tdata  = {DATA_WIDTH{1'b0}};
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = {NUM_PORTS{1'b0}};
    if (state_q == ARB_BUSY) begin
      m_axis_tdata           = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
      m_axis_tvalid          = s_axis_tvalid[grant_q];
      m_axis_tlast           = s_axis_tlast[grant_q];
      s_axis_tready[grant_q] = m_axis_tready;
    end else begin
      s_axis_tready = {NUM_PORTS{1'b0}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= {PORT_W{1'b0}};
      last_q  <= PORT_W'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  eth_tag_fifo #(
    .WIDTH (PORT_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (tag_push_s),
    .din_i       (grant_d),
    .pop_i       (meta_done),
    .dout_o      (meta_port),
    .empty_o     (tag_empty_s),
    .full_o      (tag_full),
    .underflow_o (tag_underflow)
  );

  assign meta_port_valid = ~tag_empty_s;

`ifdef ETH_ARB_STATS_EN
  logic [ARB_CNT_W-1:0] cnt_q [NUM_PORTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        cnt_q[i] <= {ARB_CNT_W{1'b0}};
      end
    end else if (eop_s) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + {{(ARB_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    assign frame_count[g*ARB_CNT_W +: ARB_CNT_W] = cnt_q[g];
  end
`endif

endmodule
